iram_wr_arb: RTL
================

# iram_wr_arb

Write-port arbiter for the shared 128-bit instruction/data SRAM (`x_aqe_iram`). It sits between three write sources and the single SRAM write port: the UART program loader (`uart2sys_*`), the system write path (`sys_wren` / `sys_data` / `sys_final_addr`) and the CPU AXI write path. Each cycle it grants at most one source, using round-robin arbitration with optional burst lock, a starvation guard and a loader-only mode. The winning write is issued as a registered SRAM write strobe.

## Interface

Parameters:
- ADDR_W, 20, SRAM line address width (byte address bits [23:4])
- DATA_W, 128, line width; byte strobe width is DATA_W/8
- MAX_BURST, 16, maximum consecutive grants to one locked requester; range 1..255
- WAIT_LIMIT, 8, cycles a pending request may wait before it is force-granted; range 2..15

Ports (requester index: uart=0, sys=1, cpu=2):
- clk  in  1  clock, single domain
- rst_b  in  1  asynchronous, active-low reset
- load_mode  in  1  when 1, only uart is eligible; sys and cpu are stalled
- uart_req / sys_req / cpu_req  in  1 each  write request; held until ack
- uart_lock / sys_lock / cpu_lock  in  1 each  request to keep the grant for the next beat
- uart_addr / sys_addr / cpu_addr  in  ADDR_W each  line address
- uart_data / sys_data / cpu_data  in  DATA_W each  write data
- uart_strb / sys_strb / cpu_strb  in  DATA_W/8 each  byte enables
- uart_ack / sys_ack / cpu_ack  out  1 each  one-cycle accept pulse
- ram_wen  out  1  SRAM write enable
- ram_addr  out  ADDR_W  SRAM line address
- ram_wdata  out  DATA_W  SRAM write data
- ram_wstrb  out  DATA_W/8  SRAM byte enables
- grant_id  out  2  index of the last issued write
- busy  out  1  high while a locked burst owns the port

## Operation

Request handshake:
- A requester asserts req with addr, data and strb stable until it sees ack.
- ack is combinational and goes high in the cycle the request is granted.
- The requester may present its next beat in the cycle after ack.

Eligibility and arbitration:
- A requester is eligible when req=1 and (load_mode=0 or index=0).
- Decision order:
  1. Forced grant: the lowest-index eligible requester whose wait counter has reached WAIT_LIMIT−1.
  2. Lock owner: if it is still eligible and burst_cnt < MAX_BURST.
  3. Round-robin: scan from rr_ptr.

Arbiter states:
- IDLE: no owner. A grant to a requester with lock=1 moves to BURST(owner), burst_cnt=1.
- BURST(owner): each owner grant increments burst_cnt. The state returns to IDLE when any of the following occurs:
  - the owner deasserts lock or req;
  - the owner loses to a forced grant;
  - burst_cnt reaches MAX_BURST while another eligible requester is pending. If nobody else is pending, the owner continues and burst_cnt saturates.

Round-robin pointer:
- rr_ptr = (grantee+1) mod 3, updated on every non-lock grant and on burst exit.

Wait counters:
- One 4-bit counter per requester.
- Increments each cycle the requester is eligible but not granted.
- Clears when the requester is granted or its req=0.
- Does not increment while the requester is stalled by load_mode.

Datapath:
- On a grant, the winner's addr, data and strb are registered onto ram_*, and ram_wen=1 in the next cycle.
- ram_wen=0 when there is no grant.
- Same-address writes from different sources are issued in grant order; the last issued write wins.

## Timing

Reset (asynchronous, rst_b=0):
- ram_wen=0, ram_addr=0, ram_wdata=0, ram_wstrb=0, grant_id=0, busy=0.
- All ack outputs are 0 (no grants while in reset).
- rr_ptr=0, state=IDLE, all counters=0.

Latency and throughput:
- Grant to ram_wen: 1 cycle. Throughput is one write per cycle.
- busy=1 in the cycles after entering BURST, until the IDLE transition.

Boundary conditions:
- Reset mid-burst: the registered write is dropped (ram_wen is forced to 0 immediately), and the lock is released.
- load_mode rising mid-burst:
  - If the owner is sys or cpu, the burst ends that cycle and uart is granted if it is pending.
  - Stalled requesters keep req held and receive no ack.
- Simultaneous forced grants: the lowest index wins; the others keep their counters saturated at WAIT_LIMIT−1.
- All req=0: no ack, ram_wen=0 next cycle, state goes to IDLE.

## Test plan

- Single write: uart_req, addr=0x00002, data=0x7, strb=0xFFFF. Required: uart_ack in cycle N; in N+1, ram_wen=1, ram_addr=0x00002, ram_wdata=0x7, grant_id=0.
- Round-robin: all three req held continuously with lock=0 from reset. Required grant sequence 0,1,2,0,1,2; ram_wen stays high every cycle after the first.
- Burst cap: cpu_lock=1 with cpu_req held for 40 cycles, sys_req pending, MAX_BURST=16, WAIT_LIMIT=15. Required: 16 cpu acks, then one sys ack (sys forced by its wait counter at the 15th wait cycle if that comes first), and busy drops on the exit cycle.
- Starvation: WAIT_LIMIT=8, MAX_BURST=255, uart locked and continuous, sys pending. Required: sys_ack no later than the 8th cycle after sys_req rises.
- load_mode: load_mode=1 with sys_req and uart_req held. Required: only uart_ack pulses and sys_ack=0. Then load_mode→0: required sys_ack within 2 cycles.
- Reset mid-burst: rst_b low during cpu burst beat 5. Required: ram_wen=0 and busy=0 immediately; after release, first grant follows rr_ptr=0 order.

Source files
------------

// File: rtl/iram_wr_arb.sv
// Write-port arbiter for the shared instruction/data SRAM: round-robin over
// uart/sys/cpu with burst lock, starvation guard and loader-only mode.
module iram_wr_arb #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 128,
  parameter int MAX_BURST  = 16,
  parameter int WAIT_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                load_mode,
  input  logic                uart_req,
  input  logic                sys_req,
  input  logic                cpu_req,
  input  logic                uart_lock,
  input  logic                sys_lock,
  input  logic                cpu_lock,
  input  logic [ADDR_W-1:0]   uart_addr,
  input  logic [ADDR_W-1:0]   sys_addr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   uart_data,
  input  logic [DATA_W-1:0]   sys_data,
  input  logic [DATA_W-1:0]   cpu_data,
  input  logic [DATA_W/8-1:0] uart_strb,
  input  logic [DATA_W/8-1:0] sys_strb,
  input  logic [DATA_W/8-1:0] cpu_strb,
  output logic                uart_ack,
  output logic                sys_ack,
  output logic                cpu_ack,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  output logic [1:0]          grant_id,
  output logic                busy
);

  localparam int         STRB_W    = DATA_W / 8;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  localparam logic [3:0] WAIT_SAT  = 4'(WAIT_LIMIT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_owner, w_owner_nxt;
  logic [7:0]        r_burst_cnt, w_burst_cnt_nxt;
  logic [1:0]        r_rr_ptr;
  logic [3:0]        r_wait [3];

  logic [2:0]        w_req, w_lock, w_elig, w_force, w_gnt_oh, w_rr_pick;
  logic              w_others, w_own_ok, w_own_path, w_gnt_vld;
  logic [1:0]        w_gnt_id;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [STRB_W-1:0] w_sel_strb;

  logic              r_ram_wen;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [STRB_W-1:0] r_ram_wstrb;
  logic [1:0]        r_grant_id;

  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 0; k < 3; k++) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (!pick[2] && elig[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  assign w_req     = {cpu_req, sys_req, uart_req};
  assign w_lock    = {cpu_lock, sys_lock, uart_lock};
  assign w_elig    = w_req & {~load_mode, ~load_mode, 1'b1};
  assign w_others  = |(w_elig & ~(3'b001 << r_owner));
  assign w_own_ok  = (r_state == ST_BURST) && w_elig[r_owner] && w_lock[r_owner] &&
                     ((r_burst_cnt < BURST_MAX) || !w_others);
  assign w_rr_pick = rr_pick(w_elig, r_rr_ptr);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_force = 3'b000;
    for (int i = 0; i < 3; i++) w_force[i] = w_elig[i] && (r_wait[i] == WAIT_SAT);
  end

  // Forced grant beats the lock owner, which beats round-robin.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_id   = 2'd0;
    w_own_path = 1'b0;
    if (|w_force) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = w_force[0] ? 2'd0 : (w_force[1] ? 2'd1 : 2'd2);
    end else if (w_own_ok) begin
      w_gnt_vld  = 1'b1;
      w_gnt_id   = r_owner;
      w_own_path = 1'b1;
    end else if (w_rr_pick[2]) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = w_rr_pick[1:0];
    end
  end

  assign w_gnt_oh = w_gnt_vld ? (3'b001 << w_gnt_id) : 3'b000;

  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_b) begin
      r_state     <= ST_IDLE;
      r_owner     <= 2'd0;
      r_burst_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Any grant without lock, or no grant at all, leaves the burst.
  always_comb begin
    w_state_nxt     = ST_IDLE;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = 8'd0;
    if (w_gnt_vld && w_lock[w_gnt_id]) begin
      w_state_nxt = ST_BURST;
      w_owner_nxt = w_gnt_id;
      if (!w_own_path)                    w_burst_cnt_nxt = 8'd1;
      else if (r_burst_cnt == BURST_MAX)  w_burst_cnt_nxt = r_burst_cnt;
      else                                w_burst_cnt_nxt = r_burst_cnt + 8'd1;
    end
  end

  always_comb begin
    uart_ack = rst_b & w_gnt_oh[0];
    sys_ack  = rst_b & w_gnt_oh[1];
    cpu_ack  = rst_b & w_gnt_oh[2];
    busy     = (r_state == ST_BURST);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rr_ptr <= 2'd0;
      for (int i = 0; i < 3; i++) r_wait[i] <= 4'd0;
    end else begin
      if (w_gnt_vld) r_rr_ptr <= (w_gnt_id == 2'd2) ? 2'd0 : w_gnt_id + 2'd1;
      for (int i = 0; i < 3; i++) begin
        if (!w_req[i] || w_gnt_oh[i])                    r_wait[i] <= 4'd0;
        else if (w_elig[i] && (r_wait[i] != WAIT_SAT))   r_wait[i] <= r_wait[i] + 4'd1;
      end
    end
  end

  always_comb begin
    case (w_gnt_id)
      2'd1:    begin w_sel_addr = sys_addr;  w_sel_data = sys_data;  w_sel_strb = sys_strb;  end
      2'd2:    begin w_sel_addr = cpu_addr;  w_sel_data = cpu_data;  w_sel_strb = cpu_strb;  end
      default: begin w_sel_addr = uart_addr; w_sel_data = uart_data; w_sel_strb = uart_strb; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: the write-data registers are reset too, so ram_* reads all-zero out of reset.
    if (!rst_b) begin
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wstrb <= '0;
      r_grant_id  <= 2'd0;
    end else begin
      r_ram_wen <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_ram_addr  <= w_sel_addr;
        r_ram_wdata <= w_sel_data;
        r_ram_wstrb <= w_sel_strb;
        r_grant_id  <= w_gnt_id;
      end
    end
  end

  assign ram_wen   = r_ram_wen;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wstrb = r_ram_wstrb;
  assign grant_id  = r_grant_id;

endmodule
